// File: rtl/spmv_network_stage.sv
// Registered SpMV reduction-network merge node: combines equal-row lane pairs and
// holds results in a two-entry (main + skid) output buffer so no ready path is combinational.
module spmv_network_stage #(
    parameter int LOCATION    = 3,
    parameter int PARALLELISM = 50,
    parameter int ID_WIDTH    = 16,
    parameter int VAL_WIDTH   = 32,
    parameter int OUT_WIDTH   = VAL_WIDTH + 1,
    parameter int SATURATE    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_a_valid,
    input  logic                 in_b_valid,
    input  logic [ID_WIDTH-1:0]  in_a_id,
    input  logic [ID_WIDTH-1:0]  in_b_id,
    input  logic [VAL_WIDTH-1:0] in_a_val,
    input  logic [VAL_WIDTH-1:0] in_b_val,
    output logic                 in_ready,
    output logic                 out_a_valid,
    output logic                 out_b_valid,
    output logic [ID_WIDTH-1:0]  out_a_id,
    output logic [ID_WIDTH-1:0]  out_b_id,
    output logic [OUT_WIDTH-1:0] out_a_val,
    output logic [OUT_WIDTH-1:0] out_b_val,
    input  logic                 out_ready,
    input  logic                 stat_clear,
    output logic [31:0]          merge_count
);

    localparam bit TOWARDS_CENTER = (2 * LOCATION > PARALLELISM);
    localparam int SUM_W          = OUT_WIDTH + 1;

    typedef struct packed {
        logic                 a_vld;
        logic [ID_WIDTH-1:0]  a_id;
        logic [OUT_WIDTH-1:0] a_val;
        logic                 b_vld;
        logic [ID_WIDTH-1:0]  b_id;
        logic [OUT_WIDTH-1:0] b_val;
    } beat_t;

    typedef enum logic [1:0] {EMPTY, MAIN, FULL} buf_state_t;

    function automatic logic [OUT_WIDTH-1:0] sext_out(input logic [VAL_WIDTH-1:0] v);
        return OUT_WIDTH'($signed(v));
    endfunction

    // The extra sum bit disagreeing with the output sign bit means the sum left the OUT_WIDTH range.
    function automatic logic [OUT_WIDTH-1:0] sat_sum(input logic [SUM_W-1:0] s);
        if (SATURATE != 0 && (s[SUM_W-1] != s[SUM_W-2]))
            return s[SUM_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        return s[OUT_WIDTH-1:0];
    endfunction

    logic             merge_p0;
    logic [SUM_W-1:0] sum_p0;
    beat_t            beat_p0;
    beat_t            main_p1;
    beat_t            skid_p1;
    buf_state_t       state_p1;
    logic             accept;
    logic             transfer;
    logic [31:0]      merge_cnt;

    // Stage p0: merge decision and lane formatting on the incoming beat
    always_comb begin
        merge_p0      = in_a_valid & in_b_valid & (in_a_id == in_b_id);
        sum_p0        = SUM_W'($signed(in_a_val)) + SUM_W'($signed(in_b_val));
        beat_p0.a_vld = in_a_valid;
        beat_p0.a_id  = in_a_id;
        beat_p0.a_val = sext_out(in_a_val);
        beat_p0.b_vld = in_b_valid;
        beat_p0.b_id  = in_b_id;
        beat_p0.b_val = sext_out(in_b_val);
        if (merge_p0) begin
            if (TOWARDS_CENTER) begin
                beat_p0.a_val = sat_sum(sum_p0);
                beat_p0.b_vld = 1'b0;
                beat_p0.b_val = '0;
            end else begin
                beat_p0.b_val = sat_sum(sum_p0);
                beat_p0.a_vld = 1'b0;
                beat_p0.a_val = '0;
            end
        end
    end

    assign in_ready = rst_n & (state_p1 != FULL);
    assign accept   = (in_a_valid | in_b_valid) & in_ready;
    assign transfer = (main_p1.a_vld | main_p1.b_vld) & out_ready;

    // Stage p1: main/skid output buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= EMPTY;
            main_p1  <= '0;
            skid_p1  <= '0;
        end else begin
            case (state_p1)
                EMPTY: begin
                    if (accept) begin
                        main_p1  <= beat_p0;
                        state_p1 <= MAIN;
                    end
                end
                MAIN: begin
                    if (accept && transfer) begin
                        main_p1 <= beat_p0;
                    end else if (accept) begin
                        skid_p1  <= beat_p0;
                        state_p1 <= FULL;
                    end else if (transfer) begin
                        main_p1.a_vld <= 1'b0;
                        main_p1.b_vld <= 1'b0;
                        state_p1      <= EMPTY;
                    end
                end
                FULL: begin
                    if (transfer) begin
                        main_p1  <= skid_p1;
                        state_p1 <= MAIN;
                    end
                end
                default: state_p1 <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            merge_cnt <= '0;
        else if (stat_clear)
            merge_cnt <= '0;
        else if (accept && merge_p0)
            merge_cnt <= merge_cnt + 32'd1;
    end

    assign merge_count = merge_cnt;
    assign out_a_valid = main_p1.a_vld;
    assign out_a_id    = main_p1.a_id;
    assign out_a_val   = main_p1.a_val;
    assign out_b_valid = main_p1.b_vld;
    assign out_b_id    = main_p1.b_id;
    assign out_b_val   = main_p1.b_val;

endmodule

// File: tb/tb_spmv_network_stage.sv
// Bench for spmv_network_stage: vector table, width/saturation variants, backpressure,
// reset and counter corner cases, and randomized traffic against a queue-based model.
module tb_spmv_network_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_a_valid, in_b_valid, out_ready, stat_clear;
    logic [15:0] in_a_id, in_b_id;
    logic [31:0] in_a_val, in_b_val;

    // dA: LOCATION 3, 32->33 bit wrap, lane b is centre
    logic        a_rdy, a_av, a_bv;
    logic [15:0] a_aid, a_bid;
    logic [32:0] a_aval, a_bval;
    logic [31:0] a_cnt;
    // dB: LOCATION 30 (lane a centre), 8->9 bit
    logic        b_rdy, b_av, b_bv;
    logic [15:0] b_aid, b_bid;
    logic [8:0]  b_aval, b_bval;
    logic [31:0] b_cnt;
    // dC: 8->8 saturating; dD: 8->8 wrapping
    logic        c_rdy, c_av, c_bv, d_rdy, d_av, d_bv;
    logic [15:0] c_aid, c_bid, d_aid, d_bid;
    logic [7:0]  c_aval, c_bval, d_aval, d_bval;
    logic [31:0] c_cnt, d_cnt;

    always #5 clk = ~clk;

    spmv_network_stage #(.LOCATION(3), .PARALLELISM(50), .ID_WIDTH(16), .VAL_WIDTH(32),
                         .OUT_WIDTH(33), .SATURATE(0)) dA (
        .clk(clk), .rst_n(rst_n), .in_a_valid(in_a_valid), .in_b_valid(in_b_valid),
        .in_a_id(in_a_id), .in_b_id(in_b_id), .in_a_val(in_a_val), .in_b_val(in_b_val),
        .in_ready(a_rdy), .out_a_valid(a_av), .out_b_valid(a_bv), .out_a_id(a_aid),
        .out_b_id(a_bid), .out_a_val(a_aval), .out_b_val(a_bval), .out_ready(out_ready),
        .stat_clear(stat_clear), .merge_count(a_cnt));

    spmv_network_stage #(.LOCATION(30), .PARALLELISM(50), .ID_WIDTH(16), .VAL_WIDTH(8),
                         .OUT_WIDTH(9), .SATURATE(0)) dB (
        .clk(clk), .rst_n(rst_n), .in_a_valid(in_a_valid), .in_b_valid(in_b_valid),
        .in_a_id(in_a_id), .in_b_id(in_b_id), .in_a_val(in_a_val[7:0]), .in_b_val(in_b_val[7:0]),
        .in_ready(b_rdy), .out_a_valid(b_av), .out_b_valid(b_bv), .out_a_id(b_aid),
        .out_b_id(b_bid), .out_a_val(b_aval), .out_b_val(b_bval), .out_ready(out_ready),
        .stat_clear(stat_clear), .merge_count(b_cnt));

    spmv_network_stage #(.LOCATION(3), .PARALLELISM(50), .ID_WIDTH(16), .VAL_WIDTH(8),
                         .OUT_WIDTH(8), .SATURATE(1)) dC (
        .clk(clk), .rst_n(rst_n), .in_a_valid(in_a_valid), .in_b_valid(in_b_valid),
        .in_a_id(in_a_id), .in_b_id(in_b_id), .in_a_val(in_a_val[7:0]), .in_b_val(in_b_val[7:0]),
        .in_ready(c_rdy), .out_a_valid(c_av), .out_b_valid(c_bv), .out_a_id(c_aid),
        .out_b_id(c_bid), .out_a_val(c_aval), .out_b_val(c_bval), .out_ready(out_ready),
        .stat_clear(stat_clear), .merge_count(c_cnt));

    spmv_network_stage #(.LOCATION(3), .PARALLELISM(50), .ID_WIDTH(16), .VAL_WIDTH(8),
                         .OUT_WIDTH(8), .SATURATE(0)) dD (
        .clk(clk), .rst_n(rst_n), .in_a_valid(in_a_valid), .in_b_valid(in_b_valid),
        .in_a_id(in_a_id), .in_b_id(in_b_id), .in_a_val(in_a_val[7:0]), .in_b_val(in_b_val[7:0]),
        .in_ready(d_rdy), .out_a_valid(d_av), .out_b_valid(d_bv), .out_a_id(d_aid),
        .out_b_id(d_bid), .out_a_val(d_aval), .out_b_val(d_bval), .out_ready(out_ready),
        .stat_clear(stat_clear), .merge_count(d_cnt));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [99:0] out_a_beat();
        return {a_av, a_aid, a_aval, a_bv, a_bid, a_bval};
    endfunction

    // Reference: 33-bit output never overflows for 32-bit inputs, so plain 64-bit sums suffice.
    function automatic logic [99:0] model(input logic av, input logic [15:0] aid, input logic [31:0] aval,
                                          input logic bv, input logic [15:0] bid, input logic [31:0] bval);
        longint sa, sb, s;
        sa = longint'($signed(aval));
        sb = longint'($signed(bval));
        s  = sa + sb;
        if (av && bv && aid == bid)
            return {1'b0, aid, 33'd0, 1'b1, bid, s[32:0]};
        return {av, aid, sa[32:0], bv, bid, sb[32:0]};
    endfunction

    task automatic drive(input logic av, input logic [15:0] aid, input logic [31:0] aval,
                         input logic bv, input logic [15:0] bid, input logic [31:0] bval);
        in_a_valid = av; in_a_id = aid; in_a_val = aval;
        in_b_valid = bv; in_b_id = bid; in_b_val = bval;
    endtask

    task automatic idle();
        drive(1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0);
    endtask

    typedef struct {
        logic        av;
        logic [15:0] aid;
        logic [31:0] aval;
        logic        bv;
        logic [15:0] bid;
        logic [31:0] bval;
        logic [99:0] exp;
        int          mrg;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [8:0]  exp_b9;
        logic [7:0]  exp_sat;
        logic [7:0]  exp_wrap;
    } sat_t;

    vec_t          tbl[8];
    sat_t          stbl[3];
    logic [99:0]   q[$];
    logic [99:0]   bp_exp[4];
    int            model_cnt;
    int            nrecv;
    int            k;

    initial begin
        tbl[0] = '{1, 16'd7, 32'd10, 1, 16'd7, 32'hFFFF_FFFD,
                   {1'b0, 16'd7, 33'd0, 1'b1, 16'd7, 33'd7}, 1};
        tbl[1] = '{1, 16'd5, 32'd100, 1, 16'd6, 32'd200,
                   {1'b1, 16'd5, 33'd100, 1'b1, 16'd6, 33'd200}, 0};
        tbl[2] = '{1, 16'd9, 32'hFFFF_FFFB, 0, 16'd0, 32'd0,
                   {1'b1, 16'd9, 33'h1_FFFF_FFFB, 1'b0, 16'd0, 33'd0}, 0};
        tbl[3] = '{1, 16'd3, 32'h8000_0000, 1, 16'd3, 32'h8000_0000,
                   {1'b0, 16'd3, 33'd0, 1'b1, 16'd3, 33'h1_0000_0000}, 1};
        tbl[4] = '{0, 16'd4, 32'd77, 1, 16'd11, 32'd42,
                   {1'b0, 16'd4, 33'd77, 1'b1, 16'd11, 33'd42}, 0};
        tbl[5] = '{1, 16'd8, 32'd1, 1, 16'd9, 32'd1,
                   {1'b1, 16'd8, 33'd1, 1'b1, 16'd9, 33'd1}, 0};
        tbl[6] = '{1, 16'd2, 32'h7FFF_FFFF, 1, 16'd2, 32'h7FFF_FFFF,
                   {1'b0, 16'd2, 33'd0, 1'b1, 16'd2, 33'h0_FFFF_FFFE}, 1};
        tbl[7] = '{1, 16'd12, 32'hFFFF_FFF6, 1, 16'd12, 32'd4,
                   {1'b0, 16'd12, 33'd0, 1'b1, 16'd12, 33'h1_FFFF_FFFA}, 1};
        stbl[0] = '{32'd127, 32'd127, 9'h0FE, 8'h7F, 8'hFE};
        stbl[1] = '{32'd127, 32'd1, 9'h080, 8'h7F, 8'h80};
        stbl[2] = '{32'hFFFF_FF80, 32'hFFFF_FF80, 9'h100, 8'h80, 8'h00};

        idle();
        out_ready  = 1'b1;
        stat_clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", a_rdy, 1'b0);
        chk("reset_outputs", out_a_beat(), 100'd0);
        chk("reset_count", a_cnt, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", a_rdy, 1'b1);

        model_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].av, tbl[i].aid, tbl[i].aval, tbl[i].bv, tbl[i].bid, tbl[i].bval);
            @(negedge clk);
            chk($sformatf("table_%0d", i), out_a_beat(), tbl[i].exp);
            model_cnt += tbl[i].mrg;
            if (i == 0) begin
                chk("centre_a_merge", {b_av, b_aid, b_aval, b_bv}, {1'b1, 16'd7, 9'd7, 1'b0});
                chk("sat_inst_merge", {c_av, c_bv, c_bval}, {1'b0, 1'b1, 8'd7});
                chk("wrap_inst_merge", {d_av, d_bv, d_bval}, {1'b0, 1'b1, 8'd7});
            end
        end
        chk("table_merge_count", a_cnt, model_cnt);

        drive(1'b0, 16'd1, 32'd5, 1'b0, 16'd1, 32'd6);
        @(negedge clk);
        chk("empty_beat_not_stored", {a_av, a_bv}, 2'b00);
        chk("empty_beat_not_counted", a_cnt, model_cnt);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'd1, stbl[i].a, 1'b1, 16'd1, stbl[i].b);
            @(negedge clk);
            chk($sformatf("width9_%0d", i), b_aval, stbl[i].exp_b9);
            chk($sformatf("saturate_%0d", i), c_bval, stbl[i].exp_sat);
            chk($sformatf("wrap_%0d", i), d_bval, stbl[i].exp_wrap);
        end

        drive(1'b1, 16'd7, 32'd1, 1'b1, 16'd7, 32'd2);
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
        chk("clear_beats_merge", a_cnt, 32'd0);
        @(negedge clk);
        chk("count_after_clear", a_cnt, 32'd1);

        force dA.merge_cnt = 32'hFFFF_FFFF;
        #1 release dA.merge_cnt;
        @(negedge clk);
        chk("count_wrap", a_cnt, 32'd0);
        idle();
        @(negedge clk);

        // Backpressure: four pass-through beats, out_ready low for the first three cycles.
        for (int i = 0; i < 4; i++)
            bp_exp[i] = model(1'b1, 16'(20 + i), 32'(1000 + i), 1'b1, 16'(40 + i), 32'(i));
        k = 0;
        nrecv = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 3);
            if (cyc == 2) begin
                chk("bp_ready_low", a_rdy, 1'b0);
                chk("bp_stall_head", out_a_beat(), bp_exp[0]);
            end
            if (cyc == 4) chk("bp_ready_back", a_rdy, 1'b1);
            if ((a_av | a_bv) && out_ready && nrecv < 4) begin
                chk($sformatf("bp_order_%0d", nrecv), out_a_beat(), bp_exp[nrecv]);
                nrecv++;
            end
            if (k < 4 && a_rdy) begin
                drive(1'b1, 16'(20 + k), 32'(1000 + k), 1'b1, 16'(40 + k), 32'(k));
                k++;
            end else begin
                idle();
            end
            @(negedge clk);
        end
        chk("bp_delivered", nrecv, 4);

        out_ready = 1'b0;
        drive(1'b1, 16'd3, 32'd5, 1'b1, 16'd3, 32'd6);
        repeat (2) @(negedge clk);
        chk("full_ready_low", a_rdy, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_full_outputs", out_a_beat(), 100'd0);
        chk("rst_full_count", a_cnt, 32'd0);
        chk("rst_full_ready", a_rdy, 1'b0);
        idle();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", a_rdy, 1'b1);
        chk("post_rst_no_output", {a_av, a_bv}, 2'b00);

        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
        model_cnt = 0;
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic av, bv;
            logic [15:0] aid, bid;
            logic [31:0] aval, bval;
            out_ready = ($urandom_range(0, 3) != 0);
            chk("rnd_present", a_av | a_bv, q.size() != 0);
            chk("rnd_ready", a_rdy, q.size() < 2);
            if ((a_av | a_bv) && out_ready && q.size() != 0) begin
                chk("rnd_beat", out_a_beat(), q[0]);
                void'(q.pop_front());
            end
            av = 1'($urandom_range(0, 1));
            bv = 1'($urandom_range(0, 1));
            aid = 16'($urandom_range(0, 3));
            bid = 16'($urandom_range(0, 3));
            aval = $urandom();
            bval = $urandom();
            drive(av, aid, aval, bv, bid, bval);
            if ((av | bv) && a_rdy) begin
                q.push_back(model(av, aid, aval, bv, bid, bval));
                if (av && bv && aid == bid) model_cnt++;
            end
            @(negedge clk);
        end
        idle();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if ((a_av | a_bv) && q.size() != 0) begin
                chk("drain_beat", out_a_beat(), q[0]);
                void'(q.pop_front());
            end
            @(negedge clk);
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_no_output", {a_av, a_bv}, 2'b00);
        chk("rnd_merge_count", a_cnt, model_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
